// File: rtl/mouse_grid_picker.sv
// mouse_grid_picker: converts a left-button click in pixel coordinates into a
// 10x10 board cell index {row, col} and a one-cycle pick request. Row and
// column are found by repeated subtraction of CELL_SIZE, so no divider is used.
module mouse_grid_picker #(
  parameter int GRID_X0   = 112,
  parameter int GRID_Y0   = 184,
  parameter int CELL_SIZE = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        left,
  output logic        pick_ship,
  output logic [7:0]  mouse_pos,
  output logic        busy
);

  // Grid bounds as 12-bit quantities; the end bounds are exclusive.
  localparam logic [11:0] X_START = 12'(GRID_X0);
  localparam logic [11:0] Y_START = 12'(GRID_Y0);
  localparam logic [11:0] X_END   = 12'(GRID_X0 + 10 * CELL_SIZE);
  localparam logic [11:0] Y_END   = 12'(GRID_Y0 + 10 * CELL_SIZE);
  localparam logic [11:0] CELL    = 12'(CELL_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CHECK        = 3'd1,
    ST_DIVIDE       = 3'd2,
    ST_PULSE        = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } state_t;

  state_t      state_r;
  logic        left_d_r;
  logic [11:0] x_cap_r;
  logic [11:0] y_cap_r;
  logic [11:0] x_rem_r;
  logic [11:0] y_rem_r;
  logic [3:0]  col_cnt_r;
  logic [3:0]  row_cnt_r;

  logic        press_s;
  logic        outside_s;
  logic        x_step_s;
  logic        y_step_s;

  // Rising-edge detect on the button, bounds test on the captured click, and
  // per-axis "another whole cell remains" flags for the divider.
  always_comb begin
    press_s   = left & ~left_d_r;
    outside_s = (x_cap_r < X_START) || (x_cap_r >= X_END) ||
                (y_cap_r < Y_START) || (y_cap_r >= Y_END);
    x_step_s  = (x_rem_r >= CELL);
    y_step_s  = (y_rem_r >= CELL);
  end

  // Conversion FSM with registered pick, cell index and busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      left_d_r  <= 1'b1;
      x_cap_r   <= 12'd0;
      y_cap_r   <= 12'd0;
      x_rem_r   <= 12'd0;
      y_rem_r   <= 12'd0;
      col_cnt_r <= 4'd0;
      row_cnt_r <= 4'd0;
      pick_ship <= 1'b0;
      mouse_pos <= 8'h00;
      busy      <= 1'b0;
    end else begin
      left_d_r <= left;
      case (state_r)
        ST_IDLE: begin
          pick_ship <= 1'b0;
          if (press_s && enable) begin
            x_cap_r <= xpos;
            y_cap_r <= ypos;
            busy    <= 1'b1;
            state_r <= ST_CHECK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (outside_s) begin
            state_r <= ST_WAIT_RELEASE;
          end else begin
            x_rem_r   <= x_cap_r - X_START;
            y_rem_r   <= y_cap_r - Y_START;
            col_cnt_r <= 4'd0;
            row_cnt_r <= 4'd0;
            state_r   <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (!x_step_s && !y_step_s) begin
            pick_ship <= 1'b1;
            mouse_pos <= {row_cnt_r, col_cnt_r};
            state_r   <= ST_PULSE;
          end else begin
            if (x_step_s) begin
              x_rem_r   <= x_rem_r - CELL;
              col_cnt_r <= col_cnt_r + 4'd1;
            end
            if (y_step_s) begin
              y_rem_r   <= y_rem_r - CELL;
              row_cnt_r <= row_cnt_r + 4'd1;
            end
            state_r <= ST_DIVIDE;
          end
        end
        ST_PULSE: begin
          pick_ship <= 1'b0;
          state_r   <= ST_WAIT_RELEASE;
        end
        ST_WAIT_RELEASE: begin
          if (!left) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_RELEASE;
          end
        end
        default: begin
          pick_ship <= 1'b0;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_grid_picker.sv
// Scoreboard bench for mouse_grid_picker: stimulus pushes expected picks
// (cell index and cycle) from an arithmetic reference model; a monitor pops
// and compares whenever pick_ship is seen high.
module tb_mouse_grid_picker;

  localparam int X0   = 112;
  localparam int Y0   = 184;
  localparam int CELL = 40;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        pick_ship;
  logic [7:0]  mouse_pos;
  logic        busy;

  typedef struct {
    int pos;
    int cyc;
  } pick_t;

  pick_t exp_q[$];
  int    exp_pos;
  int    cyc;
  int    n_total;
  int    n_pass;

  mouse_grid_picker #(.GRID_X0(X0), .GRID_Y0(Y0), .CELL_SIZE(CELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .xpos      (xpos),
    .ypos      (ypos),
    .left      (left),
    .pick_ship (pick_ship),
    .mouse_pos (mouse_pos),
    .busy      (busy)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter; after posedge+1 it holds the index of the current cycle.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
  endfunction

  // Monitor: every pick must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && pick_ship) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pick: got pick mouse_pos=0x%0h, expected no pick at cycle %0d",
                 mouse_pos, cyc);
      end else begin
        pick_t e;
        e = exp_q.pop_front();
        chk("pick_pos", int'(mouse_pos), e.pos);
        chk("pick_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for a recognised press at cycle n.
  function automatic void model_press(int x, int y, int n);
    int row, col, m;
    pick_t e;
    if (x >= X0 && x < X0 + 10 * CELL && y >= Y0 && y < Y0 + 10 * CELL) begin
      col = (x - X0) / CELL;
      row = (y - Y0) / CELL;
      m = (row > col) ? row : col;
      e.pos = row * 16 + col;
      e.cyc = n + 3 + m;
      exp_q.push_back(e);
      exp_pos = e.pos;
    end
  endfunction

  // One click: press with coordinates, hold, release, settle, then check.
  task automatic click(int x, int y, bit en, int hold, bit scramble);
    xpos = 12'(x);
    ypos = 12'(y);
    enable = en;
    left = 1'b1;
    if (en) model_press(x, y, cyc);
    step();
    chk("busy_after_press", int'(busy), int'(en));
    for (int i = 1; i < hold; i++) begin
      if (scramble) begin
        xpos = 12'($urandom_range(0, 4095));
        ypos = 12'($urandom_range(0, 4095));
        enable = 1'($urandom_range(0, 1));
      end
      step();
    end
    if (en && hold >= 3) chk("busy_while_held", int'(busy), 1);
    left = 1'b0;
    enable = 1'b1;
    repeat (16) step();
    chk("busy_after_release", int'(busy), 0);
    chk("mouse_pos_held", int'(mouse_pos), exp_pos);
    chk("picks_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    exp_pos = 0;
    rst    = 1'b1;
    enable = 1'b0;
    xpos   = 12'd0;
    ypos   = 12'd0;
    left   = 1'b0;
    repeat (3) step();
    chk("reset_pick", int'(pick_ship), 0);
    chk("reset_pos", int'(mouse_pos), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (3) step();

    // Directed corners and boundaries.
    click(112, 184, 1'b1, 20, 1'b0);
    click(511, 583, 1'b1, 20, 1'b0);
    click(152, 263, 1'b1, 5, 1'b0);
    click(111, 200, 1'b1, 10, 1'b0);
    click(512, 300, 1'b1, 10, 1'b0);
    click(300, 183, 1'b1, 10, 1'b0);
    click(300, 584, 1'b1, 10, 1'b0);
    click(200, 200, 1'b0, 10, 1'b0);
    click(200, 200, 1'b1, 100, 1'b0);
    click(200, 200, 1'b1, 8, 1'b0);
    click(511, 583, 1'b1, 1, 1'b1);

    // Reset during DIVIDE with the button still held: conversion aborted,
    // and no pick until the button is released and pressed again.
    xpos = 12'd511;
    ypos = 12'd583;
    enable = 1'b1;
    left = 1'b1;
    model_press(511, 583, cyc);
    repeat (5) step();
    rst = 1'b1;
    exp_q.delete();
    exp_pos = 0;
    step();
    chk("abort_busy", int'(busy), 0);
    chk("abort_pos", int'(mouse_pos), 0);
    chk("abort_pick", int'(pick_ship), 0);
    rst = 1'b0;
    repeat (20) step();
    chk("held_through_reset_busy", int'(busy), 0);
    left = 1'b0;
    repeat (3) step();
    chk("held_through_reset_pos", int'(mouse_pos), 0);
    click(400, 400, 1'b1, 4, 1'b0);

    // Randomised clicks, with inputs scrambled after capture.
    for (int t = 0; t < 40; t++) begin
      click($urandom_range(60, 640), $urandom_range(130, 700),
            1'($urandom_range(0, 3) != 0), $urandom_range(1, 20),
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
